mic_frame_serializer: RTL and testbench
=======================================

MIC_FRAME_SERIALIZER -- requirements
Module: mic_frame_serializer

Interface
REQ-001 SHALL have parameter WL, default 24, sample word length in bits.
REQ-002 SHALL have parameter NUM, default 8, number of microphone channels.
REQ-003 SHALL have parameter DC_SHIFT, default 10, DC-blocker time-constant shift.
REQ-004 SHALL have port aud_bclk  input  1  clock; all logic rising-edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port adc_data  input  WL*NUM  parallel samples; channel i at bits [i*WL +: WL], two's complement.
REQ-007 SHALL have port rx_done  input  1  level, high while adc_data is stable and complete.
REQ-008 SHALL have port m_valid  output  1  stream word valid.
REQ-009 SHALL have port m_ready  input  1  downstream accepts the word.
REQ-010 SHALL have port m_data  output  WL  sample word.
REQ-011 SHALL have port m_chan  output  clog2(NUM)  channel index of m_data.
REQ-012 SHALL have port m_last  output  1  high with channel NUM-1.
REQ-013 SHALL have port overrun  output  1  one-cycle pulse when a frame is dropped.
REQ-014 SHALL have port frame_cnt  output  16  count of fully sent frames; wraps 0xFFFF->0.

Function
REQ-015 SHALL register rx_done once per cycle; frame_start = rx_done AND NOT rx_done_q.
REQ-016 SHALL use FSM states IDLE and SEND.
REQ-017 On frame_start in IDLE: SHALL copy adc_data to a shadow register, set chan=0, enter SEND; m_valid high on the next cycle.
REQ-018 In SEND: m_valid=1, m_data=shadow[chan] (after processing, REQ-027), m_chan=chan, m_last=(chan==NUM-1).
REQ-019 Outputs SHALL stay stable while m_valid=1 and m_ready=0.
REQ-020 On handshake (m_valid AND m_ready) with chan<NUM-1: chan SHALL increment.
REQ-021 On handshake with chan==NUM-1: SHALL return to IDLE and increment frame_cnt the same edge.
REQ-022 On frame_start in SEND without a final handshake the same cycle: SHALL drop the new frame, keep shadow unchanged, and pulse overrun for exactly one cycle.
REQ-023 On frame_start coinciding with the final handshake: SHALL capture the new frame, stay in SEND with chan=0, increment frame_cnt, and not pulse overrun.
REQ-024 A frame_start during IDLE SHALL never assert overrun.
REQ-025 If rx_done stays high across frames, only the rising edge SHALL start a frame.

Reset
REQ-026 On rst: state=IDLE, chan=0, shadow=0, rx_done_q=0, m_valid=0, m_data=0, m_chan=0, m_last=0, overrun=0, frame_cnt=0, DC accumulators=0. Reset mid-SEND aborts the frame; no partial count.

Configuration
REQ-027 With MIC_DC_BLOCK_EN defined: m_data = sat_WL(x - (acc[chan]>>>DC_SHIFT)), where x is the shadow sample.
REQ-028 With MIC_DC_BLOCK_EN defined: each channel keeps a signed accumulator acc of WL+DC_SHIFT+1 bits; on that channel's handshake, acc += x - (acc>>>DC_SHIFT).
REQ-029 With MIC_DC_BLOCK_EN defined: saturation clamps to [-2^(WL-1), 2^(WL-1)-1].
REQ-030 Without MIC_DC_BLOCK_EN: m_data = shadow sample unmodified, no accumulators synthesized; handshake timing SHALL be identical with or without the macro.

Structure
REQ-031 Package mic_stream_pkg SHALL hold the FSM state typedef (IDLE, SEND) and default WL/NUM/DC_SHIFT constants.
REQ-032 Sub-module mic_dc_blocker SHALL hold the accumulator array, subtraction and saturation, and SHALL be instantiated only under MIC_DC_BLOCK_EN.

Verification
REQ-033 Basic frame: channel i = i+1, rx_done rises, m_ready=1 -> 8 words 1..8, m_chan 0..7, m_last on word 8, frame_cnt=1.
REQ-034 Backpressure: m_ready toggles 1,0,0,1 -> no word lost or repeated, m_data constant during stalls.
REQ-035 Overrun: m_ready=0, second rx_done rising edge -> one-cycle overrun, shadow data unchanged, frame_cnt unchanged.
REQ-036 Coincident: second rx_done edge on the same cycle as the m_last handshake -> no overrun, next word is channel 0 of the new frame.
REQ-037 Reset mid-SEND at chan=3 -> m_valid=0 next cycle, frame_cnt=0, a fresh frame restarts at chan 0.
REQ-038 DC (macro on, DC_SHIFT=4): constant input 1000 on channel 0 over 200 frames -> first output 1000, output decays monotonically to |m_data|<=16.

Source files
------------

// File: rtl/mic_stream_pkg.sv
// -----------------------------------------------------------------------------
// mic_stream_pkg
//   Shared definitions for the microphone frame serializer:
//     - default sample word length, channel count and DC-blocker shift
//     - FSM state type used by mic_frame_serializer
// -----------------------------------------------------------------------------
package mic_stream_pkg;

    localparam int MIC_WL_DEFAULT       = 24;
    localparam int MIC_NUM_DEFAULT      = 8;
    localparam int MIC_DC_SHIFT_DEFAULT = 10;

    // IDLE: waiting for a new frame; SEND: streaming shadow words out.
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } mic_state_e;

endpackage

// File: rtl/mic_dc_blocker.sv
// -----------------------------------------------------------------------------
// mic_dc_blocker
//   Per-channel leaky DC estimator and subtractor for the serializer output.
//   Output  : y = sat_WL(x - (acc[chan] >>> DC_SHIFT))
//   Update  : on update_i, acc[chan] += x - (acc[chan] >>> DC_SHIFT)
//   The accumulator is only touched on the handshake of its own channel, so the
//   output stays constant while the downstream stalls.
//
// Ports
//   aud_bclk  in   clock, rising edge
//   rst       in   asynchronous active-high reset (clears all accumulators)
//   x_i       in   WL   raw two's-complement sample of the current channel
//   chan_i    in   CW   channel index of x_i
//   update_i  in   1    handshake of the current word; commits the acc update
//   y_o       out  WL   DC-corrected, saturated sample
// -----------------------------------------------------------------------------
module mic_dc_blocker
    import mic_stream_pkg::*;
#(
    parameter int WL       = MIC_WL_DEFAULT,
    parameter int NUM      = MIC_NUM_DEFAULT,
    parameter int DC_SHIFT = MIC_DC_SHIFT_DEFAULT
) (
    input  logic                       aud_bclk,
    input  logic                       rst,
    input  logic signed [WL-1:0]       x_i,
    input  logic [$clog2(NUM)-1:0]     chan_i,
    input  logic                       update_i,
    output logic signed [WL-1:0]       y_o
);

    localparam int CW = $clog2(NUM);
    // One guard bit above the steady-state magnitude |x| * 2^DC_SHIFT.
    localparam int AW = WL + DC_SHIFT + 1;

    localparam logic signed [AW-1:0] SAT_MAX = (AW'(1) << (WL - 1)) - AW'(1);
    localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;

    logic signed [AW-1:0] acc_q [NUM];
    logic signed [AW-1:0] acc_sel;
    logic signed [AW-1:0] acc_shr;
    logic signed [AW-1:0] x_ext;
    logic signed [AW-1:0] diff;
    logic [NUM-1:0]       hit;

    assign acc_sel = acc_q[chan_i];
    assign acc_shr = acc_sel >>> DC_SHIFT;
    assign x_ext   = AW'(x_i);
    // The same unsaturated difference drives both the output and the update.
    assign diff    = x_ext - acc_shr;

    genvar gi;
    generate
        for (gi = 0; gi < NUM; gi++) begin : g_hit
            assign hit[gi] = update_i && (chan_i == CW'(gi));
        end
    endgenerate

    always_ff @(posedge aud_bclk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM; i++) begin
                if (hit[i]) begin
                    acc_q[i] <= acc_q[i] + diff;
                end
            end
        end
    end

    always_comb begin
        y_o = diff[WL-1:0];
        if (diff > SAT_MAX) begin
            y_o = SAT_MAX[WL-1:0];
        end else if (diff < SAT_MIN) begin
            y_o = SAT_MIN[WL-1:0];
        end
    end

endmodule

// File: rtl/mic_frame_serializer.sv
// -----------------------------------------------------------------------------
// mic_frame_serializer
//   Captures a parallel frame of NUM microphone samples on the rising edge of
//   rx_done and streams it out one channel per valid/ready handshake.
//   A frame arriving while the previous one is still being sent is dropped
//   (overrun pulse), unless it lands exactly on the final handshake, in which
//   case it is captured seamlessly.
//
//   Optional feature: define MIC_DC_BLOCK_EN to insert a per-channel DC
//   blocker (mic_dc_blocker) on m_data. Handshake timing is identical either
//   way; without the macro m_data is the raw shadow sample.
//
// Ports
//   aud_bclk   in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   adc_data   in   WL*NUM  parallel samples, channel i at [i*WL +: WL]
//   rx_done    in   1       high while adc_data is stable and complete
//   m_valid    out  1       stream word valid
//   m_ready    in   1       downstream accepts the word
//   m_data     out  WL      sample word
//   m_chan     out  clog2(NUM) channel of m_data
//   m_last     out  1       high with channel NUM-1
//   overrun    out  1       one-cycle pulse when a frame is dropped
//   frame_cnt  out  16      completed frames, wrapping
// -----------------------------------------------------------------------------
module mic_frame_serializer
    import mic_stream_pkg::*;
#(
    parameter int WL       = MIC_WL_DEFAULT,
    parameter int NUM      = MIC_NUM_DEFAULT,
    parameter int DC_SHIFT = MIC_DC_SHIFT_DEFAULT
) (
    input  logic                    aud_bclk,
    input  logic                    rst,
    input  logic [WL*NUM-1:0]       adc_data,
    input  logic                    rx_done,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [WL-1:0]           m_data,
    output logic [$clog2(NUM)-1:0]  m_chan,
    output logic                    m_last,
    output logic                    overrun,
    output logic [15:0]             frame_cnt
);

    localparam int              CW        = $clog2(NUM);
    localparam logic [CW-1:0]   LAST_CHAN = CW'(NUM - 1);
    localparam logic            ONE_CHAN  = (NUM == 1);

    mic_state_e          state_q;
    logic                rx_done_q;
    logic [WL*NUM-1:0]   shadow_q;
    logic [CW-1:0]       chan_q;
    logic                m_valid_q;
    logic                m_last_q;
    logic                overrun_q;
    logic [15:0]         frame_cnt_q;

    logic                frame_start;
    logic                handshake;
    logic                final_hs;
    logic [CW-1:0]       chan_inc;
    logic [WL-1:0]       shadow_words [NUM];
    logic [WL-1:0]       x_sel;

    assign frame_start = rx_done && !rx_done_q;
    assign handshake   = m_valid_q && m_ready;
    assign final_hs    = handshake && (chan_q == LAST_CHAN);
    assign chan_inc    = chan_q + CW'(1);

    // -------------------------------------------------------------------------
    // Control FSM; all stream outputs except m_data are registered here.
    // -------------------------------------------------------------------------
    always_ff @(posedge aud_bclk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rx_done_q   <= 1'b0;
            shadow_q    <= '0;
            chan_q      <= '0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            overrun_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            rx_done_q <= rx_done;
            overrun_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (frame_start) begin
                        shadow_q  <= adc_data;
                        chan_q    <= '0;
                        m_valid_q <= 1'b1;
                        m_last_q  <= ONE_CHAN;
                        state_q   <= SEND;
                    end
                end
                SEND: begin
                    if (final_hs) begin
                        frame_cnt_q <= frame_cnt_q + 16'd1;
                        chan_q      <= '0;
                        if (frame_start) begin
                            // Back-to-back frame: no gap in m_valid.
                            shadow_q <= adc_data;
                            m_last_q <= ONE_CHAN;
                        end else begin
                            m_valid_q <= 1'b0;
                            m_last_q  <= 1'b0;
                            state_q   <= IDLE;
                        end
                    end else begin
                        if (handshake) begin
                            chan_q   <= chan_inc;
                            m_last_q <= (chan_inc == LAST_CHAN);
                        end
                        // Still busy with the current frame: drop the new one.
                        if (frame_start) begin
                            overrun_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    m_valid_q <= 1'b0;
                    m_last_q  <= 1'b0;
                    chan_q    <= '0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Sample select: slice the shadow frame into words, pick the current one.
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM; gi++) begin : g_words
            assign shadow_words[gi] = shadow_q[gi*WL +: WL];
        end
    endgenerate

    assign x_sel = shadow_words[chan_q];

`ifdef MIC_DC_BLOCK_EN
    mic_dc_blocker #(
        .WL       (WL),
        .NUM      (NUM),
        .DC_SHIFT (DC_SHIFT)
    ) u_dc_blocker (
        .aud_bclk (aud_bclk),
        .rst      (rst),
        .x_i      (x_sel),
        .chan_i   (chan_q),
        .update_i (handshake),
        .y_o      (m_data)
    );
`else
    assign m_data = x_sel;
`endif

    assign m_valid   = m_valid_q;
    assign m_chan    = chan_q;
    assign m_last    = m_last_q;
    assign overrun   = overrun_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_mic_frame_serializer.sv
`timescale 1ns/1ps
module tb_mic_frame_serializer;

    localparam int WL  = 24;
    localparam int NUM = 8;
    localparam int DCS = 4;
    localparam int CW  = $clog2(NUM);
    localparam longint MAXV = (64'sd1 <<< (WL - 1)) - 64'sd1;
    localparam longint MINV = -(64'sd1 <<< (WL - 1));

    logic                aud_bclk = 1'b0;
    logic                rst;
    logic [WL*NUM-1:0]   adc_data;
    logic                rx_done;
    logic                m_valid;
    logic                m_ready;
    logic [WL-1:0]       m_data;
    logic [CW-1:0]       m_chan;
    logic                m_last;
    logic                overrun;
    logic [15:0]         frame_cnt;

    always #5 aud_bclk = ~aud_bclk;

    mic_frame_serializer #(
        .WL       (WL),
        .NUM      (NUM),
        .DC_SHIFT (DCS)
    ) dut (
        .aud_bclk  (aud_bclk),
        .rst       (rst),
        .adc_data  (adc_data),
        .rx_done   (rx_done),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_chan    (m_chan),
        .m_last    (m_last),
        .overrun   (overrun),
        .frame_cnt (frame_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------------
    // Reference model: a queue of words still owed to the downstream.
    // ---------------------------------------------------------------------
    typedef struct { logic [WL-1:0] x; int ch; } word_t;
    typedef struct { logic [WL-1:0] d; int ch; logic last; } obs_t;

    word_t       mq[$];
    longint      acc[NUM];
    logic        prev_rx;
    logic        exp_ov;
    logic [15:0] exp_cnt;
    obs_t        hs_log[$];
    int          ov_seen = 0;

    function automatic logic [WL-1:0] model_out(input word_t w);
`ifdef MIC_DC_BLOCK_EN
        logic signed [WL-1:0] xs;
        longint v;
        xs = w.x;
        v  = longint'(xs) - (acc[w.ch] >>> DCS);
        if (v > MAXV) v = MAXV;
        else if (v < MINV) v = MINV;
        return v[WL-1:0];
`else
        return w.x;
`endif
    endfunction

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < NUM; i++) acc[i] = 0;
        prev_rx = 1'b0;
        exp_ov  = 1'b0;
        exp_cnt = 16'd0;
    endtask

    initial model_reset();

    // Compare process: checks outputs, logs traffic, then advances the model
    // with the inputs that the coming rising edge will sample.
    always @(negedge aud_bclk) begin
        word_t w;
        obs_t  o;
        logic  fs;
        logic  exp_valid;
        logic signed [WL-1:0] xs;
        if (rst) begin
            model_reset();
            check("rst_m_valid", 64'(m_valid), 64'(0));
            check("rst_m_data", 64'(m_data), 64'(0));
            check("rst_m_chan", 64'(m_chan), 64'(0));
            check("rst_m_last", 64'(m_last), 64'(0));
            check("rst_overrun", 64'(overrun), 64'(0));
            check("rst_frame_cnt", 64'(frame_cnt), 64'(0));
        end else begin
            exp_valid = (mq.size() > 0);
            check("m_valid", 64'(m_valid), 64'(exp_valid));
            if (exp_valid) begin
                w = mq[0];
                check("m_data", 64'(m_data), 64'(model_out(w)));
                check("m_chan", 64'(m_chan), 64'(w.ch));
                check("m_last", 64'(m_last), 64'(w.ch == NUM - 1));
            end
            check("overrun", 64'(overrun), 64'(exp_ov));
            check("frame_cnt", 64'(frame_cnt), 64'(exp_cnt));

            if (overrun) ov_seen++;
            if (m_valid && m_ready) begin
                o.d = m_data; o.ch = int'(m_chan); o.last = m_last;
                hs_log.push_back(o);
            end

            fs      = rx_done && !prev_rx;
            prev_rx = rx_done;
            exp_ov  = 1'b0;
            if (exp_valid && m_ready) begin
                w = mq.pop_front();
`ifdef MIC_DC_BLOCK_EN
                xs = w.x;
                acc[w.ch] = acc[w.ch] + (longint'(xs) - (acc[w.ch] >>> DCS));
`else
                xs = '0;
`endif
                if (w.ch == NUM - 1) exp_cnt = exp_cnt + 16'd1;
            end
            if (fs) begin
                if (mq.size() == 0) begin
                    for (int c = 0; c < NUM; c++) begin
                        w.x = adc_data[c*WL +: WL];
                        w.ch = c;
                        mq.push_back(w);
                    end
                end else begin
                    exp_ov = 1'b1;
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------------
    task automatic step();
        @(posedge aud_bclk);
        #2;
    endtask

    task automatic set_frame(input int base);
        for (int c = 0; c < NUM; c++) adc_data[c*WL +: WL] = WL'(base + c);
    endtask

    initial begin
        int     ov0;
        int     cnt0;
        int     pat[4];
        bit     found;
        logic [WL-1:0] prev_d;
        logic signed [WL-1:0] sd;
        int     n0;
        bit     mono;

        pat = '{1, 0, 0, 1};
        rst = 1'b1; rx_done = 1'b0; m_ready = 1'b0; adc_data = '0;
        repeat (3) step();
        rst = 1'b0;
        step();
        check("post_rst_valid", 64'(m_valid), 64'(0));
        check("post_rst_cnt", 64'(frame_cnt), 64'(0));

        // Basic frame: channel i carries i+1.
        set_frame(1);
        m_ready = 1'b1;
        hs_log.delete();
        rx_done = 1'b1;
        repeat (12) step();
        rx_done = 1'b0;
        check("basic_words", 64'(hs_log.size()), 64'(8));
        for (int i = 0; i < NUM && i < hs_log.size(); i++) begin
            check("basic_data", 64'(hs_log[i].d), 64'(i + 1));
            check("basic_chan", 64'(hs_log[i].ch), 64'(i));
            check("basic_last", 64'(hs_log[i].last), 64'(i == NUM - 1));
        end
        check("basic_cnt", 64'(frame_cnt), 64'(1));
        step();

        // Backpressure: ready pattern 1,0,0,1.
        set_frame(24'h100);
        hs_log.delete();
        rx_done = 1'b1;
        for (int k = 0; k < 40; k++) begin
            m_ready = pat[k % 4][0];
            step();
        end
        rx_done = 1'b0;
        check("bp_words", 64'(hs_log.size()), 64'(8));
        for (int i = 0; i < NUM && i < hs_log.size(); i++) begin
            check("bp_chan", 64'(hs_log[i].ch), 64'(i));
`ifndef MIC_DC_BLOCK_EN
            check("bp_data", 64'(hs_log[i].d), 64'(24'h100 + i));
`endif
        end
        check("bp_cnt", 64'(frame_cnt), 64'(2));

        // Overrun: stalled frame, second rising edge is dropped.
        m_ready = 1'b0;
        step();
        set_frame(24'h200);
        rx_done = 1'b1;
        repeat (3) step();
        rx_done = 1'b0;
        step();
        ov0 = ov_seen;
        set_frame(24'h300);
        rx_done = 1'b1;
        repeat (3) step();
        check("ovr_pulses", 64'(ov_seen - ov0), 64'(1));
        check("ovr_cnt", 64'(frame_cnt), 64'(2));
        check("ovr_chan", 64'(m_chan), 64'(0));
`ifndef MIC_DC_BLOCK_EN
        check("ovr_shadow", 64'(m_data), 64'(24'h200));
`endif
        hs_log.delete();
        m_ready = 1'b1;
        repeat (12) step();
        rx_done = 1'b0;
        check("ovr_cnt_after", 64'(frame_cnt), 64'(3));
        check("ovr_pulses_after", 64'(ov_seen - ov0), 64'(1));
`ifndef MIC_DC_BLOCK_EN
        if (hs_log.size() > 0) check("ovr_first_word", 64'(hs_log[0].d), 64'(24'h200));
`endif
        step();

        // Coincident: new rising edge on the final handshake edge.
        ov0  = ov_seen;
        cnt0 = int'(frame_cnt);
        hs_log.delete();
        set_frame(24'h400);
        rx_done = 1'b1;
        step();
        rx_done = 1'b0;
        repeat (7) step();
        set_frame(24'h500);
        rx_done = 1'b1;
        repeat (12) step();
        rx_done = 1'b0;
        check("coin_overrun", 64'(ov_seen - ov0), 64'(0));
        check("coin_words", 64'(hs_log.size()), 64'(16));
        check("coin_cnt", 64'(frame_cnt), 64'(cnt0 + 2));
        if (hs_log.size() > 8) begin
            check("coin_next_chan", 64'(hs_log[8].ch), 64'(0));
`ifndef MIC_DC_BLOCK_EN
            check("coin_next_data", 64'(hs_log[8].d), 64'(24'h500));
`endif
        end
        step();

        // Reset in the middle of a frame at channel 3.
        set_frame(24'h600);
        rx_done = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            step();
            if (m_valid && m_chan == 3) begin
                found = 1'b1;
                m_ready = 1'b0;
            end
        end
        check("mid_reached_chan3", 64'(found), 64'(1));
        rst = 1'b1;
        step();
        check("mid_valid", 64'(m_valid), 64'(0));
        check("mid_cnt", 64'(frame_cnt), 64'(0));
        rst = 1'b0;
        rx_done = 1'b0;
        step();
        hs_log.delete();
        m_ready = 1'b1;
        set_frame(24'h700);
        rx_done = 1'b1;
        repeat (12) step();
        rx_done = 1'b0;
        check("mid_restart_words", 64'(hs_log.size()), 64'(8));
        if (hs_log.size() > 0) check("mid_restart_chan", 64'(hs_log[0].ch), 64'(0));
        check("mid_restart_cnt", 64'(frame_cnt), 64'(1));

        // Randomised traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 5) == 0) rx_done = ~rx_done;
            m_ready = ($urandom_range(0, 3) != 0);
            for (int c = 0; c < NUM; c++) adc_data[c*WL +: WL] = WL'($urandom);
            step();
        end
        rx_done = 1'b0;
        m_ready = 1'b1;
        repeat (20) step();
        check("rand_drained", 64'(m_valid), 64'(0));

`ifdef MIC_DC_BLOCK_EN
        // DC decay on a constant channel-0 input.
        rst = 1'b1;
        step();
        rst = 1'b0;
        adc_data = '0;
        adc_data[WL-1:0] = WL'(1000);
        hs_log.delete();
        for (int f = 0; f < 200; f++) begin
            rx_done = 1'b1;
            step();
            rx_done = 1'b0;
            repeat (10) step();
        end
        n0 = 0;
        mono = 1'b1;
        prev_d = '0;
        for (int i = 0; i < hs_log.size(); i++) begin
            if (hs_log[i].ch == 0) begin
                if (n0 == 0) check("dc_first", 64'(hs_log[i].d), 64'(1000));
                else if ($signed(hs_log[i].d) > $signed(prev_d)) mono = 1'b0;
                prev_d = hs_log[i].d;
                n0++;
            end
        end
        check("dc_frames", 64'(n0), 64'(200));
        check("dc_monotonic", 64'(mono), 64'(1));
        sd = prev_d;
        check("dc_settled", 64'((sd <= 16) && (sd >= -16)), 64'(1));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
